// File: rtl/inst_prefetch_pkg.sv
// Shared definitions for the instruction prefetcher: word width, default
// reset PC, PC increment, FSM state encoding and the queue entry layout.
package inst_prefetch_pkg;

    localparam int unsigned WORD_WIDTH       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } pf_entry_t;

    // Force an address onto a word boundary
    function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] a);
        return {a[WORD_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO holding {pc, instr} pairs.
// Push, pop and flush are sampled on the rising edge; flush wins over both.
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             push_do, pop_do;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign pop_do  = pop_i && !empty_o;
    assign push_do = push_i && (!full_o || pop_do);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_do) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_do)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_do, pop_do})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; no reset needed since reads are qualified by occupancy
    always_ff @(posedge clk_i) begin
        if (push_do && !flush_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: in-order instruction prefetcher with up to two outstanding
// memory requests, a DEPTH-entry queue and redirect/drain handling.
// Optional feature macro: PREFETCH_BYPASS_EN (response bypasses an empty queue).
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stallF,
    output logic        validF,
    output logic [31:0] instrF,
    output logic [31:0] pcF
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pf_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  discard_q, discard_d;
    logic [2:0]  redir_discard;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0] occ_sum;
    pf_entry_t   fifo_wdata, fifo_head;
    logic        req_ok, grant, resp_run, bypass;

    assign occ_sum  = {1'b0, fifo_count} + {{(CW-1){1'b0}}, out_q};
    assign req_ok   = (state_q == ST_RUN) && !fifo_full &&
                      (occ_sum < (CW+1)'(DEPTH)) && (out_q < 2'd2);
    assign imem_req  = req_ok && !rst;
    assign imem_addr = fetch_pc_q;
    assign grant     = imem_req && imem_gnt;
    assign resp_run  = imem_rvalid && (state_q == ST_RUN);

`ifdef PREFETCH_BYPASS_EN
    assign bypass = resp_run && fifo_empty && !redirect && !stallF && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push  = resp_run && !redirect && !bypass;
    assign fifo_pop   = !fifo_empty && !stallF && !redirect;
    assign fifo_wdata = {tag0_q, imem_rdata};

    // Responses still owed by memory at redirect time; a same-cycle grant adds
    // one, a same-cycle response (dropped) removes one.
    assign redir_discard = {1'b0, discard_q} + {1'b0, out_q}
                         + {2'b00, grant} - {2'b00, imem_rvalid};

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_WIDTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // FSM next state: drain while discarded responses are still owed
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (redirect && (redir_discard != 3'd0)) state_d = ST_DRAIN;
            ST_DRAIN: if (discard_d == 2'd0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM outputs: bypassed response, else queue head, else zeros
    always_comb begin
        validF = 1'b0;
        instrF = '0;
        pcF    = '0;
        if (bypass) begin
            validF = 1'b1;
            instrF = imem_rdata;
            pcF    = tag0_q;
        end else if (!fifo_empty) begin
            validF = 1'b1;
            instrF = fifo_head.instr;
            pcF    = fifo_head.pc;
        end
    end

    // Fetch PC, outstanding tag queue and discard counter next values
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag0_d     = tag0_q;
        tag1_d     = tag1_q;
        out_d      = out_q;
        discard_d  = discard_q;
        if (resp_run && (out_d != 2'd0)) begin
            tag0_d = tag1_q;
            out_d  = out_d - 2'd1;
        end
        if (grant) begin
            if (out_d == 2'd0) tag0_d = fetch_pc_q;
            else               tag1_d = fetch_pc_q;
            out_d      = out_d + 2'd1;
            fetch_pc_d = fetch_pc_q + PC_INCR;
        end
        if (redirect) begin
            out_d      = '0;
            fetch_pc_d = word_align(redirect_pc);
            discard_d  = redir_discard[1:0];
        end else if ((state_q == ST_DRAIN) && imem_rvalid && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= word_align(RESET_PC);
            tag0_q     <= '0;
            tag1_q     <= '0;
            out_q      <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag0_q     <= tag0_d;
            tag1_q     <= tag1_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
        end
    end

endmodule
